// File: rtl/sram_stream_reader.sv
// sram_stream_reader
//   Read-side client for a 1R1W SRAM with a one-cycle registered-address read.
//   Takes a burst descriptor (start address, length-1) and streams the words
//   out over valid/ready with an end-of-burst marker. A 3-entry output FIFO
//   plus a credit check on issued reads absorbs both the SRAM read latency
//   and downstream backpressure without losing or duplicating words.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   req_valid/ready     burst descriptor handshake
//   req_addr, req_len   start address, word count minus one
//   sram_read_*         SRAM read port (data valid the cycle after enable)
//   out_valid/ready     output stream handshake
//   out_data, out_last  stream word and end-of-burst marker
//   busy                FSM not in IDLE
//   stall_cycles        (SRAM_STREAM_READER_PERF_EN only) saturating count of
//                       cycles with out_valid && !out_ready
//
// Build option
//   SRAM_STREAM_READER_PERF_EN  adds the stall_cycles port and counter.

module sram_stream_reader #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 4,
  parameter int LEN_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [LEN_SIZE-1:0]  req_len,
  output logic                 sram_read_enable,
  output logic [ADDR_SIZE-1:0] sram_read_address,
  input  logic [WORD_SIZE-1:0] sram_read_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
`ifdef SRAM_STREAM_READER_PERF_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] FIFO_DEPTH = 2'd3;

  state_t               r_state;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [LEN_SIZE-1:0]  r_remaining;

  // A read issued last cycle: its data is on sram_read_data this cycle.
  logic                 r_inflight;
  logic                 r_inflight_last;

  // Output FIFO, 3 entries of {data, last}
  logic [WORD_SIZE-1:0] r_fifo_data [3];
  logic [2:0]           r_fifo_last;
  logic [1:0]           r_rd_ptr;
  logic [1:0]           r_wr_ptr;
  logic [1:0]           r_count;

  logic                 w_credit;
  logic                 w_issue;
  logic                 w_deq;
  logic                 w_head_last;
  logic [WORD_SIZE-1:0] w_head_data;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Entries already held plus the one read in flight must leave room for
  // the read about to issue. A dequeue this cycle is deliberately ignored so
  // the check depends only on registered state.
  assign w_credit = ({1'b0, r_count} + {2'b00, r_inflight}) < {1'b0, FIFO_DEPTH};
  assign w_issue  = (r_state == S_ISSUE) && w_credit && !rst;
  assign w_deq    = (r_count != 2'd0) && out_ready && !rst;

  always_comb begin
    w_head_data = r_fifo_data[0];
    w_head_last = r_fifo_last[0];
    case (r_rd_ptr)
      2'd1: begin
        w_head_data = r_fifo_data[1];
        w_head_last = r_fifo_last[1];
      end
      2'd2: begin
        w_head_data = r_fifo_data[2];
        w_head_last = r_fifo_last[2];
      end
      default: ;
    endcase
  end

  // Outputs are decoded from registered state only; rst forces them low so
  // nothing is presented while reset is being sampled.
  assign req_ready         = (r_state == S_IDLE) && !rst;
  assign busy              = (r_state != S_IDLE) && !rst;
  assign sram_read_enable  = w_issue;
  assign sram_read_address = r_addr;
  assign out_valid         = (r_count != 2'd0) && !rst;
  assign out_data          = w_head_data;
  assign out_last          = w_head_last && out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_last     <= '0;
      r_rd_ptr        <= 2'd0;
      r_wr_ptr        <= 2'd0;
      r_count         <= 2'd0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_remaining == '0);

      // SRAM data is only valid for one cycle, so capture unconditionally;
      // the credit check guarantees a free slot.
      if (r_inflight) begin
        r_fifo_data[r_wr_ptr] <= sram_read_data;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ptr_inc(r_wr_ptr);
      end

      if (w_deq)
        r_rd_ptr <= ptr_inc(r_rd_ptr);

      case ({r_inflight, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr      <= req_addr;
            r_remaining <= req_len;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_addr      <= r_addr + 1'b1;  // wraps modulo memory depth
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == '0)
              r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_deq && w_head_last)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SRAM_STREAM_READER_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cycles <= '0;
    else if (out_valid && !out_ready && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: behavioural SRAM, expected-word and
// expected-address queues filled on descriptor accept and drained as the
// DUT issues reads and emits words.

module tb_sram_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_addr;
  logic [7:0] req_len;
  logic       sram_read_enable;
  logic [3:0] sram_read_address;
  logic [7:0] sram_read_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
`ifdef SRAM_STREAM_READER_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  sram_stream_reader #(.WORD_SIZE(8), .ADDR_SIZE(4), .LEN_SIZE(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .req_len           (req_len),
    .sram_read_enable  (sram_read_enable),
    .sram_read_address (sram_read_address),
    .sram_read_data    (sram_read_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_last          (out_last),
    .busy              (busy)
`ifdef SRAM_STREAM_READER_PERF_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

  // SRAM: registered address, data valid the following cycle
  logic [7:0] mem [16];
  always @(posedge clk)
    if (sram_read_enable) sram_read_data <= mem[sram_read_address];

  typedef struct { logic [7:0] data; logic last; } exp_t;
  exp_t       sb_q[$];
  logic [3:0] addr_q[$];

  int n_vec = 0;
  int n_err = 0;
  int outstanding = 0;
  int ren_cnt = 0;
  int n_words = 0;
  bit rnd_ready = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (sram_read_enable) begin
      chk("credit", 32'(outstanding < 3), 1);
      chk("rd_busy", busy, 1);
      if (addr_q.size() == 0) chk("extra_rd", 1, 0);
      else chk("rd_addr", sram_read_address, addr_q.pop_front());
      outstanding++;
      ren_cnt++;
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("extra_word", 1, 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("data", out_data, e.data);
        chk("last", out_last, e.last);
      end
      outstanding--;
      n_words++;
    end
    if (req_valid && req_ready) begin
      for (int i = 0; i <= int'(req_len); i++) begin
        logic [3:0] a;
        exp_t e;
        a = 4'(int'(req_addr) + i);
        e.data = mem[a];
        e.last = (i == int'(req_len));
        sb_q.push_back(e);
        addr_q.push_back(a);
      end
    end
  end

  // Random backpressure driver
  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // All tasks start and end at posedge+1.
  task automatic send(input logic [3:0] a, input logic [7:0] l);
    int t = 0;
    req_addr = a; req_len = l; req_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      if (++t > 500) begin chk("req_timeout", 0, 1); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((sb_q.size() != 0 || busy) && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_timeout", 32'(t < 5000), 1);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    int w0, t, run;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 'h10);
    mem[5] = 8'hA5;
    repeat (3) cyc();

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ren", sram_read_enable, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    cyc();

    // Single word: cycle-exact latency
    req_valid = 1'b1; req_addr = 4'd5; req_len = 8'd0;            // cycle 0
    @(negedge clk); chk("sw_accept", req_ready, 1);
    cyc(); req_valid = 1'b0;                                       // cycle 1
    @(negedge clk);
    chk("sw_ren_c1", sram_read_enable, 1);
    chk("sw_addr_c1", sram_read_address, 5);
    cyc();                                                         // cycle 2
    @(negedge clk);
    chk("sw_ren_c2", sram_read_enable, 0);
    chk("sw_valid_c2", out_valid, 0);
    cyc();                                                         // cycle 3
    @(negedge clk);
    chk("sw_valid_c3", out_valid, 1);
    chk("sw_data_c3", out_data, 8'hA5);
    chk("sw_last_c3", out_last, 1);
    chk("sw_ready_c3", req_ready, 0);
    cyc();                                                         // cycle 4
    @(negedge clk);
    chk("sw_ready_c4", req_ready, 1);
    chk("sw_valid_c4", out_valid, 0);
    cyc();
    mem[5] = 8'h15;

    // Streaming: 8 back-to-back words
    send(4'd2, 8'd7);
    t = 0; run = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    while (out_valid && run < 20) begin run++; @(negedge clk); end
    chk("stream_run", run, 8);
    cyc();
    wait_done();

    // Wrap-around: addresses 14,15,0,1
    send(4'd14, 8'd3);
    wait_done();

    // Backpressure: only 3 reads issue while the consumer stalls
    out_ready = 1'b0; ren_cnt = 0; w0 = n_words;
    send(4'd0, 8'd9);
    repeat (12) cyc();
    chk("bp_reads", ren_cnt, 3);
    chk("bp_head", out_data, mem[0]);
    out_ready = 1'b1;
    wait_done();
    chk("bp_words", n_words - w0, 10);

    // Max-length burst, wraps the memory many times
    w0 = n_words;
    send(4'd9, 8'd255);
    wait_done();
    chk("max_words", n_words - w0, 256);

    // Random bursts under random backpressure
    rnd_ready = 1;
    for (int b = 0; b < 200; b++) begin
      mem[$urandom_range(0, 15)] = 8'($urandom);
      send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 23)));
      wait_done();
    end
    rnd_ready = 0; out_ready = 1'b1;
    cyc();

    // Reset mid-burst, during the third word
    w0 = n_words; t = 0;
    send(4'd3, 8'd7);
    while (n_words < w0 + 2 && t < 50) begin cyc(); t++; end
    rst = 1'b1;
    sb_q.delete(); addr_q.delete(); outstanding = 0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ren", sram_read_enable, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    cyc();
    w0 = n_words;
    send(4'd9, 8'd4);
    wait_done();
    chk("post_rst_words", n_words - w0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
